// File: rtl/dot_renderer_pkg.sv
// rtl/dot_renderer_pkg.sv - shared constants and types for the dot sprite renderer (DOT_SCALE2_EN selects 2x sprite scaling)
`ifndef DOT_WIDTH
`define DOT_WIDTH 8
`endif

package dot_renderer_pkg;

  // Default raster coordinate width and native sprite geometry
  localparam int DOT_COORD_W     = 10;
  localparam int DOT_SPRITE_ROWS = 8;
  localparam int DOT_ROM_AW      = 3;

  // Each ROM bit covers a SPRITE_SCALE x SPRITE_SCALE block of screen pixels
`ifdef DOT_SCALE2_EN
  localparam int SPRITE_SCALE = 2;
`else
  localparam int SPRITE_SCALE = 1;
`endif

  typedef enum logic {
    POS_IDLE    = 1'b0,
    POS_PENDING = 1'b1
  } pos_state_t;

endpackage

// File: rtl/dot_renderer_pos_sync.sv
// rtl/dot_renderer_pos_sync.sv - position handshake, pending capture and frame-aligned apply
module dot_pos_sync
  import dot_renderer_pkg::*;
#(
  parameter int COORD_W = DOT_COORD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               pos_valid,
  output logic               pos_ready,
  output logic [COORD_W-1:0] act_x,
  output logic [COORD_W-1:0] act_y,
  output logic               visible
);

  pos_state_t         state;
  logic [COORD_W-1:0] pend_x;
  logic [COORD_W-1:0] pend_y;

  // Accept one request into pending, then move it to active on the next frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= POS_IDLE;
      pos_ready <= 1'b1;
      pend_x    <= '0;
      pend_y    <= '0;
      act_x     <= '0;
      act_y     <= '0;
      visible   <= 1'b0;
    end else begin
      case (state)
        POS_IDLE: begin
          // a frame_start in this same cycle is ignored: the value waits for the next frame
          if (pos_valid && pos_ready) begin
            pend_x    <= pos_x;
            pend_y    <= pos_y;
            pos_ready <= 1'b0;
            state     <= POS_PENDING;
          end
        end
        POS_PENDING: begin
          if (frame_start) begin
            act_x     <= pend_x;
            act_y     <= pend_y;
            visible   <= 1'b1;
            pos_ready <= 1'b1;
            state     <= POS_IDLE;
          end
        end
        default: begin
          state     <= POS_IDLE;
          pos_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/dot_renderer.sv
// rtl/dot_renderer.sv - per-pixel dot sprite hit test, ROM row fetch and pixel-on output (DOT_SCALE2_EN draws the sprite 16x16)
`ifndef DOT_WIDTH
`define DOT_WIDTH 8
`endif

module dot_renderer
  import dot_renderer_pkg::*;
#(
  parameter int COORD_W     = DOT_COORD_W,
  parameter int SPRITE_ROWS = DOT_SPRITE_ROWS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COORD_W-1:0]    pix_x,
  input  logic [COORD_W-1:0]    pix_y,
  input  logic                  pix_valid,
  input  logic                  frame_start,
  input  logic [COORD_W-1:0]    pos_x,
  input  logic [COORD_W-1:0]    pos_y,
  input  logic                  pos_valid,
  output logic                  pos_ready,
  output logic [DOT_ROM_AW-1:0] rom_addr,
  input  logic [`DOT_WIDTH-1:0] rom_data,
  output logic                  dot_on,
  output logic                  dot_valid
);

  // On-screen sprite extent in pixels (rows and columns are the same size)
  localparam int EXTENT = SPRITE_ROWS * SPRITE_SCALE;
  localparam logic [DOT_ROM_AW-1:0] MSB_IDX = DOT_ROM_AW'(`DOT_WIDTH - 1);

  logic [COORD_W-1:0] act_x;
  logic [COORD_W-1:0] act_y;
  logic               visible;

  dot_pos_sync #(
    .COORD_W (COORD_W)
  ) u_pos_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .pos_valid   (pos_valid),
    .pos_ready   (pos_ready),
    .act_x       (act_x),
    .act_y       (act_y),
    .visible     (visible)
  );

  // One extra bit so a pixel left of / above the dot shows up as negative instead of wrapping
  logic [COORD_W:0]      dx;
  logic [COORD_W:0]      dy;
  logic                  hit;
  logic [DOT_ROM_AW-1:0] row_sel;
  logic [DOT_ROM_AW-1:0] col_sel;

  assign dx = {1'b0, pix_x} - {1'b0, act_x};
  assign dy = {1'b0, pix_y} - {1'b0, act_y};

  assign hit = visible
            && !dx[COORD_W] && (dx[COORD_W-1:0] < COORD_W'(EXTENT))
            && !dy[COORD_W] && (dy[COORD_W-1:0] < COORD_W'(EXTENT));

`ifdef DOT_SCALE2_EN
  assign row_sel = dy[DOT_ROM_AW:1];
  assign col_sel = dx[DOT_ROM_AW:1];
`else
  assign row_sel = dy[DOT_ROM_AW-1:0];
  assign col_sel = dx[DOT_ROM_AW-1:0];
`endif

  logic [DOT_ROM_AW-1:0] col1;
  logic                  hit1;
  logic                  v1;

  // Stage 1: register the hit decision and ROM row; the address only moves on a hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      col1     <= '0;
      hit1     <= 1'b0;
      v1       <= 1'b0;
    end else begin
      v1   <= pix_valid;
      hit1 <= pix_valid && hit;
      if (pix_valid && hit) begin
        rom_addr <= row_sel;
        col1     <= col_sel;
      end
    end
  end

  // Column 0 is the MSB of the ROM row
  logic [DOT_ROM_AW-1:0] bit_sel;
  assign bit_sel = MSB_IDX - col1;

  // Stage 2: pick the column bit from the returned row; bubbles leave dot_on low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dot_on    <= 1'b0;
      dot_valid <= 1'b0;
    end else begin
      dot_on    <= v1 && hit1 && rom_data[bit_sel];
      dot_valid <= v1;
    end
  end

endmodule

// File: tb/tb_dot_renderer.sv
// tb/tb_dot_renderer.sv - directed self-checking bench for dot_renderer (DOT_SCALE2_EN selects the scaled checks)
`ifndef DOT_WIDTH
`define DOT_WIDTH 8
`endif

module tb_dot_renderer;

  logic                  clk;
  logic                  rst_n;
  logic [9:0]            pix_x;
  logic [9:0]            pix_y;
  logic                  pix_valid;
  logic                  frame_start;
  logic [9:0]            pos_x;
  logic [9:0]            pos_y;
  logic                  pos_valid;
  logic                  pos_ready;
  logic [2:0]            rom_addr;
  logic [`DOT_WIDTH-1:0] rom_data;
  logic                  dot_on;
  logic                  dot_valid;

  int total = 0;
  int bad   = 0;

  dot_renderer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .pos_valid   (pos_valid),
    .pos_ready   (pos_ready),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .dot_on      (dot_on),
    .dot_valid   (dot_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // round dot sprite, row 0 = 00111100
  function automatic logic [7:0] rom_row(input logic [2:0] a);
    case (a)
      3'd0:    rom_row = 8'h3C;
      3'd1:    rom_row = 8'h7E;
      3'd6:    rom_row = 8'h7E;
      3'd7:    rom_row = 8'h3C;
      default: rom_row = 8'hFF;
    endcase
  endfunction

  always_comb rom_data = rom_row(rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // single isolated pixel, result sampled two edges later
  task automatic check_pix(input string tag, input int x, input int y, input logic exp_on);
    pix_x = 10'(x);
    pix_y = 10'(y);
    pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
    step();
    chk({tag, "_on"}, 32'(dot_on), 32'(exp_on));
    chk({tag, "_vld"}, 32'(dot_valid), 32'd1);
  endtask

  task automatic send_pos(input int x, input int y);
    int n;
    n = 0;
    while (!pos_ready && n < 20) begin
      step();
      n++;
    end
    chk("pos_ready_wait", 32'(pos_ready), 32'd1);
    pos_x = 10'(x);
    pos_y = 10'(y);
    pos_valid = 1'b1;
    step();
    pos_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    logic prev;
    logic [15:0] pat;
    rst_n = 1'b0;
    pix_x = '0;
    pix_y = '0;
    pix_valid = 1'b0;
    frame_start = 1'b0;
    pos_x = '0;
    pos_y = '0;
    pos_valid = 1'b0;
    step();
    step();
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_dot_on", 32'(dot_on), 32'd0);
    chk("rst_dot_valid", 32'(dot_valid), 32'd0);
    chk("rst_pos_ready", 32'(pos_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // no position yet: dot_valid tracks pix_valid two edges later, dot_on stays 0
    pat = 16'b1011_0011_1101_0110;
    prev = 1'b0;
    pulse_frame();
    for (int i = 0; i < 16; i++) begin
      pix_x = 10'(i);
      pix_y = 10'd0;
      pix_valid = pat[i];
      step();
      if (i > 0) begin
        chk("idle_valid", 32'(dot_valid), 32'(prev));
        chk("idle_on", 32'(dot_on), 32'd0);
      end
      prev = pat[i];
    end
    pix_valid = 1'b0;
    step();
    step();

`ifdef DOT_SCALE2_EN
    send_pos(0, 0);
    pulse_frame();
    check_pix("s2_4_0", 4, 0, 1'b1);
    check_pix("s2_5_1", 5, 1, 1'b1);
    check_pix("s2_3_0", 3, 0, 1'b0);
    check_pix("s2_15_4", 15, 4, 1'b1);
    check_pix("s2_16_4", 16, 4, 1'b0);
    check_pix("s2_4_16", 4, 16, 1'b0);
`else
    send_pos(100, 50);
    pulse_frame();
    chk("ready_after_apply", 32'(pos_ready), 32'd1);
    check_pix("p102_50", 102, 50, 1'b1);
    check_pix("p100_52", 100, 52, 1'b1);
    check_pix("p100_50", 100, 50, 1'b0);
    check_pix("p101_50", 101, 50, 1'b0);
    check_pix("p108_50", 108, 50, 1'b0);
    check_pix("p100_58", 100, 58, 1'b0);
    check_pix("p107_55", 107, 55, 1'b1);
    check_pix("p99_52", 99, 52, 1'b0);

    // request accepted in the same cycle as frame_start waits for the next frame
    pos_x = 10'd200;
    pos_y = 10'd100;
    pos_valid = 1'b1;
    frame_start = 1'b1;
    step();
    pos_valid = 1'b0;
    frame_start = 1'b0;
    chk("same_cyc_ready", 32'(pos_ready), 32'd0);
    check_pix("old_pos_kept", 102, 50, 1'b1);
    check_pix("new_not_yet", 202, 100, 1'b0);
    chk("still_pending", 32'(pos_ready), 32'd0);
    pulse_frame();
    chk("ready_after_next", 32'(pos_ready), 32'd1);
    check_pix("new_applied", 202, 100, 1'b1);
    check_pix("old_gone", 102, 50, 1'b0);

    // right-hand edge: no wrap to x=0
    send_pos(1020, 476);
    pulse_frame();
    check_pix("e1020", 1020, 478, 1'b1);
    check_pix("e1023", 1023, 478, 1'b1);
    check_pix("e1019", 1019, 478, 1'b0);
    check_pix("e0", 0, 478, 1'b0);
    check_pix("e3", 3, 478, 1'b0);

    // pending request plus hits in flight, then reset mid-cycle
    send_pos(100, 50);
    chk("pend_ready", 32'(pos_ready), 32'd0);
    pix_x = 10'd1022;
    pix_y = 10'd478;
    pix_valid = 1'b1;
    step();
    step();
    chk("inflight_on", 32'(dot_on), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_on", 32'(dot_on), 32'd0);
    chk("mid_rst_valid", 32'(dot_valid), 32'd0);
    chk("mid_rst_ready", 32'(pos_ready), 32'd1);
    pix_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check_pix("post_rst_edge", 1022, 478, 1'b0);
    check_pix("post_rst_origin", 2, 0, 1'b0);
    pulse_frame();
    check_pix("pend_dropped", 102, 50, 1'b0);
    chk("post_rst_ready", 32'(pos_ready), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
